// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median filter control path.
// Imported by median_window_ctrl and its helpers.
package median_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        LINE       = 2'd1,
        HBLANK     = 2'd2
    } state_e;

    localparam int WIN_SIZE    = 3;
    localparam int BORDER_ROWS = WIN_SIZE - 1;
    localparam int BORDER_COLS = WIN_SIZE - 1;

endpackage

// File: rtl/median_delay_line.sv
// Free-running shift-register chain with synchronous reset.
// Output is the input delayed by exactly DEPTH clocks.
module median_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/median_window_ctrl.sv
// Window/line-buffer sequencer for the 3x3 median filter.
// Border tagging is built only with MEDIAN_BORDER_BYPASS_EN defined.
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int H_ACT   = 64,
    parameter int V_ACT   = 64,
    parameter int AW      = 11,
    parameter int LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_de,
    input  logic          in_hsync,
    input  logic          in_vsync,
    output logic          win_ce,
    output logic          lb_we,
    output logic [AW-1:0] lb_addr,
    output logic [AW-1:0] col,
    output logic [AW-1:0] row,
    output logic          out_de,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic          border,
    output logic          frame_err
);

    localparam logic [AW-1:0] COL_LAST = AW'(H_ACT - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(V_ACT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] col_q, col_d;
    logic [AW-1:0] row_q, row_d;
    logic          vsync_q;
    logic          frame_err_q, frame_err_d;
    logic [AW-1:0] col_eff, row_eff;
    logic          vs_rise, at_origin, live, ce;

    // A vsync edge clears the counters before the same-cycle pixel is counted.
    always_comb begin
        vs_rise     = in_vsync & ~vsync_q;
        at_origin   = (col_q == '0) && (row_q == '0);
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        col_eff     = col_q;
        row_eff     = row_q;
        frame_err_d = 1'b0;
        live        = 1'b0;
        ce          = 1'b0;

        if (vs_rise) begin
            col_eff     = '0;
            row_eff     = '0;
            col_d       = '0;
            row_d       = '0;
            state_d     = LINE;
            live        = 1'b1;
            frame_err_d = (state_q != WAIT_FRAME) && !at_origin;
        end else begin
            unique case (state_q)
                WAIT_FRAME:   frame_err_d = in_de;
                LINE, HBLANK: live = 1'b1;
                default:      state_d = WAIT_FRAME;
            endcase
        end

        if (live && in_de) begin
            ce = 1'b1;
            if (col_eff == COL_LAST) begin
                col_d = '0;
                if (row_eff == ROW_LAST) begin
                    row_d   = '0;
                    state_d = WAIT_FRAME;
                end else begin
                    row_d   = row_eff + 1'b1;
                    state_d = HBLANK;
                end
            end else begin
                col_d   = col_eff + 1'b1;
                state_d = LINE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_FRAME;
            col_q       <= '0;
            row_q       <= '0;
            vsync_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            vsync_q     <= in_vsync;
            frame_err_q <= frame_err_d;
        end
    end

    assign win_ce    = ce;
    assign lb_we     = ce;
    assign lb_addr   = col_eff;
    assign col       = col_q;
    assign row       = row_q;
    assign frame_err = frame_err_q;

`ifdef MEDIAN_BORDER_BYPASS_EN
    localparam int DW = 4;
    logic b_in;
    assign b_in = in_de & ((row_eff < AW'(BORDER_ROWS)) |
                           (col_eff < AW'(BORDER_COLS)));
`else
    localparam int DW = 3;
`endif

    logic [DW-1:0] dl_in, dl_out;

`ifdef MEDIAN_BORDER_BYPASS_EN
    assign dl_in = {in_de, in_hsync, in_vsync, b_in};
    assign {out_de, out_hsync, out_vsync, border} = dl_out;
`else
    assign dl_in = {in_de, in_hsync, in_vsync};
    assign {out_de, out_hsync, out_vsync} = dl_out;
    assign border = 1'b0;
`endif

    median_delay_line #(
        .WIDTH (DW),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (dl_in),
        .q   (dl_out)
    );

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl with H_ACT=4, V_ACT=3, LATENCY=4.
// Border expectations follow MEDIAN_BORDER_BYPASS_EN.
module tb_median_window_ctrl;

    localparam int H_ACT   = 4;
    localparam int V_ACT   = 3;
    localparam int AW      = 11;
    localparam int LATENCY = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_de = 1'b0;
    logic          in_hsync = 1'b0;
    logic          in_vsync = 1'b0;
    logic          win_ce, lb_we;
    logic [AW-1:0] lb_addr, col, row;
    logic          out_de, out_hsync, out_vsync, border, frame_err;

    int total = 0;
    int fails = 0;
    logic [3:0] hist [$];

    always #5 clk = ~clk;

    median_window_ctrl #(
        .H_ACT   (H_ACT),
        .V_ACT   (V_ACT),
        .AW      (AW),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_de     (in_de),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .win_ce    (win_ce),
        .lb_we     (lb_we),
        .lb_addr   (lb_addr),
        .col       (col),
        .row       (row),
        .out_de    (out_de),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .border    (border),
        .frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_de    = 1'b0;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_out_de", out_de, 0);
        chk("rst_out_hs", out_hsync, 0);
        chk("rst_out_vs", out_vsync, 0);
        chk("rst_border", border, 0);
        chk("rst_ce", win_ce, 0);
        rst = 1'b0;
        hist.delete();
        for (int i = 0; i < LATENCY; i++) hist.push_back(4'b0);
    endtask

    // One clock: check registered state, apply inputs, check comb and delayed outputs.
    task automatic cyc(input logic de, input logic hs, input logic vs,
                       input logic e_ce, input int e_addr, input logic b,
                       input int e_col, input int e_row, input logic e_err);
        logic [3:0] old;
        logic       e_b;
        chk("col", col, e_col);
        chk("row", row, e_row);
        chk("frame_err", frame_err, e_err);
        in_de    = de;
        in_hsync = hs;
        in_vsync = vs;
        #1;
        chk("win_ce", win_ce, e_ce);
        chk("lb_we", lb_we, e_ce);
        if (e_ce) chk("lb_addr", lb_addr, e_addr);
        old = hist.pop_front();
        hist.push_back({de, hs, vs, b & de});
`ifdef MEDIAN_BORDER_BYPASS_EN
        e_b = old[0];
`else
        e_b = 1'b0;
`endif
        chk("out_de", out_de, old[3]);
        chk("out_hsync", out_hsync, old[2]);
        chk("out_vsync", out_vsync, old[1]);
        chk("border", border, e_b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Full 4x3 frame with two blank cycles between lines.
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < V_ACT; r++) begin
            for (int c = 0; c < H_ACT; c++) begin
                cyc(1, 0, 0, 1, c, (r < 2) || (c < 2), c, r, 0);
            end
            cyc(0, 1, 0, 0, 0, 0, 0, (r == V_ACT-1) ? 0 : r + 1, 0);
            cyc(0, 0, 0, 0, 0, 0, 0, (r == V_ACT-1) ? 0 : r + 1, 0);
        end
        for (int i = 0; i < LATENCY; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Stray pixels in WAIT_FRAME: no enable, one error pulse each.
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        end

        // Mid-frame vsync resync at row 1, col 2.
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < H_ACT; c++) cyc(1, 0, 0, 1, c, 1, c, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 1, 1, 1, 1, 0);
        cyc(0, 0, 1, 0, 0, 0, 2, 1, 0);
        cyc(1, 0, 0, 1, 0, 1, 0, 0, 1);
        cyc(1, 0, 0, 1, 1, 1, 1, 0, 0);
        // Vsync edge coincident with a pixel: that pixel is col 0.
        cyc(1, 0, 1, 1, 0, 1, 2, 0, 0);
        cyc(1, 0, 0, 1, 1, 1, 1, 0, 1);

        // Reset mid-line at col 2 drops the frame.
        chk("pre_rst_col", col, 2);
        do_reset();
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < LATENCY + 1; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
